// File: rtl/mux_scan_seq.sv
// Registered N_CH:1 channel selector with a manual mode and an automatic scan mode.
// A scan sweep visits every channel once, in order, and spends DWELL cycles on each.
module mux_scan_seq #(
    parameter int WIDTH = 1,
    parameter int N_CH  = 8,
    parameter int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  start,
    output logic [WIDTH-1:0]      dout,
    output logic [SEL_W-1:0]      dout_sel,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // A single-bit counter is kept for DWELL=1 so no zero-width vector is ever declared.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [SEL_W-1:0]   dout_sel_q, dout_sel_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   ch [N_CH];
    logic               dwell_last;
    logic               sweep_end;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch[k] = din[k*WIDTH +: WIDTH];
    end

    assign dwell_last = (cnt_q == CNT_LAST);
    assign sweep_end  = dwell_last && (ptr_q == PTR_LAST);

    // NOTE: the data path is reset along with the control state, because dout and
    // dout_sel must read 0 while rst_n is low, not merely carry a stale sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_sel_q   <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge
            // values; blocking here would let later lines see already-updated state.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_sel_q   <= dout_sel_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        // NOTE: defaulting every output of the block first means no path leaves a
        // signal unassigned, so no latch can be inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (mode && start)        state_d = SCAN;
            SCAN: if (!mode || sweep_end)   state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d = '0;
        cnt_d = '0;
        if (state_q == SCAN && mode) begin
            if (dwell_last) begin
                cnt_d = '0;
                ptr_d = sweep_end ? '0 : ptr_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                ptr_d = ptr_q;
            end
        end
    end

    // Manual mode wins in either state, which is also how a scan is aborted.
    always_comb begin
        dout_d       = dout_q;
        dout_sel_d   = dout_sel_q;
        dout_valid_d = 1'b0;
        done_d       = 1'b0;
        if (!mode) begin
            dout_d       = ch[sel];
            dout_sel_d   = sel;
            dout_valid_d = 1'b1;
        end else if (state_q == SCAN) begin
            dout_d       = ch[ptr_q];
            dout_sel_d   = ptr_q;
            dout_valid_d = dwell_last;
            done_d       = sweep_end;
        end
        busy_d = (state_d == SCAN);
    end

    assign dout       = dout_q;
    assign dout_sel   = dout_sel_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: manual selection, DWELL=1/3 sweeps, abort,
// mid-sweep reset and multi-bit channel packing, on three parameterisations.
module tb_mux_scan_seq;

    logic clk;
    logic rst_n;

    logic [7:0]  din1;
    logic [2:0]  sel1;
    logic        mode1, start1;
    logic        dout1;
    logic [2:0]  dsel1;
    logic        valid1, busy1, done1;

    logic [7:0]  din3;
    logic [2:0]  sel3;
    logic        mode3, start3;
    logic        dout3;
    logic [2:0]  dsel3;
    logic        valid3, busy3, done3;

    logic [15:0] dinp;
    logic [1:0]  selp;
    logic        modep, startp;
    logic [3:0]  doutp;
    logic [1:0]  dselp;
    logic        validp, busyp, donep;

    int checks;
    int failures;

    mux_scan_seq #(.WIDTH(1), .N_CH(8), .DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1), .mode(mode1), .start(start1),
        .dout(dout1), .dout_sel(dsel1), .dout_valid(valid1), .busy(busy1), .done(done1)
    );

    mux_scan_seq #(.WIDTH(1), .N_CH(8), .DWELL(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .mode(mode3), .start(start3),
        .dout(dout3), .dout_sel(dsel3), .dout_valid(valid3), .busy(busy3), .done(done3)
    );

    mux_scan_seq #(.WIDTH(4), .N_CH(4), .DWELL(1)) u_p (
        .clk(clk), .rst_n(rst_n), .din(dinp), .sel(selp), .mode(modep), .start(startp),
        .dout(doutp), .dout_sel(dselp), .dout_valid(validp), .busy(busyp), .done(donep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-derived expected samples: bit k of 8'b1110_1000 -> 0,0,0,1,0,1,1,1.
        logic [7:0] exp_bits;
        logic [3:0] pk_exp [4];
        int bcnt;
        exp_bits  = 8'b1110_1000;
        pk_exp[0] = 4'h3;
        pk_exp[1] = 4'hC;
        pk_exp[2] = 4'h5;
        pk_exp[3] = 4'hA;
        checks    = 0;
        failures  = 0;

        din1 = 8'b1110_1000; sel1 = '0; mode1 = 1'b0; start1 = 1'b0;
        din3 = 8'b1110_1000; sel3 = '0; mode3 = 1'b0; start3 = 1'b0;
        dinp = 16'hA5C3;     selp = '0; modep = 1'b1; startp = 1'b0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_dout",  dout1,  0);
        check("rst_dsel",  dsel1,  0);
        check("rst_valid", valid1, 0);
        check("rst_busy",  busy1,  0);
        check("rst_done",  done1,  0);
        check("rst_doutp", doutp,  0);
        tick();
        tick();
        rst_n = 1'b1;

        // Manual selection, one channel per cycle.
        for (int s = 0; s < 8; s++) begin
            sel1 = 3'(s);
            tick();
            check($sformatf("man_dout%0d", s),  dout1,  exp_bits[s]);
            check($sformatf("man_dsel%0d", s),  dsel1,  s);
            check($sformatf("man_valid%0d", s), valid1, 1);
        end

        // DWELL=1 sweep.
        mode1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s1_start_busy",  busy1,  1);
        check("s1_start_valid", valid1, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("s1_valid%0d", k), valid1, 1);
            check($sformatf("s1_dsel%0d", k),  dsel1,  k);
            check($sformatf("s1_dout%0d", k),  dout1,  exp_bits[k]);
            check($sformatf("s1_done%0d", k),  done1,  (k == 7) ? 1 : 0);
            check($sformatf("s1_busy%0d", k),  busy1,  (k < 7) ? 1 : 0);
        end
        tick();
        check("s1_post_valid", valid1, 0);
        check("s1_post_done",  done1,  0);
        check("s1_post_busy",  busy1,  0);

        // DWELL=3 sweep with stray start pulses while busy.
        mode3 = 1'b1; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        bcnt = busy3 ? 1 : 0;
        for (int c = 0; c < 24; c++) begin
            start3 = (c == 4 || c == 10 || c == 17) ? 1'b1 : 1'b0;
            tick();
            start3 = 1'b0;
            if (busy3) bcnt++;
            check($sformatf("s3_valid%0d", c), valid3, (c % 3 == 2) ? 1 : 0);
            check($sformatf("s3_dsel%0d", c),  dsel3,  c / 3);
            check($sformatf("s3_done%0d", c),  done3,  (c == 23) ? 1 : 0);
            if (c % 3 == 2)
                check($sformatf("s3_dout%0d", c), dout3, exp_bits[c / 3]);
        end
        check("s3_busy_cycles", bcnt, 24);
        tick();
        check("s3_post_busy",  busy3,  0);
        check("s3_post_valid", valid3, 0);
        check("s3_post_done",  done3,  0);

        // Abort during the dwell of channel 3.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("ab_pre_busy", busy3, 1);
        check("ab_pre_dsel", dsel3, 3);
        mode3 = 1'b0; sel3 = 3'd6;
        tick();
        check("ab_busy",  busy3,  0);
        check("ab_done",  done3,  0);
        check("ab_valid", valid3, 1);
        check("ab_dsel",  dsel3,  6);
        check("ab_dout",  dout3,  exp_bits[6]);
        sel3 = 3'd2;
        tick();
        check("ab_dsel2", dsel3, 2);
        check("ab_dout2", dout3, exp_bits[2]);
        check("ab_done2", done3, 0);
        mode3 = 1'b1;
        tick();
        check("ab_nostart_busy",  busy3,  0);
        check("ab_nostart_valid", valid3, 0);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("ab_restart_valid", valid3, 1);
        check("ab_restart_dsel",  dsel3,  0);
        mode3 = 1'b0;
        tick();
        check("ab_restart_abort", busy3, 0);

        // Asynchronous reset mid-sweep at channel 5.
        mode1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("rs_pre_dsel", dsel1, 5);
        check("rs_pre_dout", dout1, exp_bits[5]);
        #2 rst_n = 1'b0;
        #1;
        check("rs_dout",  dout1,  0);
        check("rs_dsel",  dsel1,  0);
        check("rs_valid", valid1, 0);
        check("rs_busy",  busy1,  0);
        check("rs_done",  done1,  0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("rs_after_busy%0d", c),  busy1,  0);
            check($sformatf("rs_after_valid%0d", c), valid1, 0);
            check($sformatf("rs_after_done%0d", c),  done1,  0);
        end

        // Packing: 4 channels of 4 bits.
        startp = 1'b1;
        tick();
        startp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("pk_dout%0d", k),  doutp,  pk_exp[k]);
            check($sformatf("pk_dsel%0d", k),  dselp,  k);
            check($sformatf("pk_valid%0d", k), validp, 1);
            check($sformatf("pk_done%0d", k),  donep,  (k == 3) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
